// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcode and funct constants,
// and the funct3 -> ALU operation mapping used by the OP and OP-IMM groups.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_SRA = 5'd7,
        ALU_SLT = 5'd8
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // i_alt selects SUB/SRA; callers must only pass it where funct7 is meaningful
    function automatic alu_op_e arith_op(input logic [2:0] i_f3, input logic i_alt);
        case (i_f3)
            F3_ADD_SUB: return i_alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return i_alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            F3_AND:     return ALU_AND;
            default:    return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder producing ALU operands, operation and
// write-back control for the subset the ALU supports.
module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [31:0]  instr,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic [4:0]   op,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [4:0]   rd,
    output logic         reg_write,
    output logic         is_branch,
    output logic         illegal
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_f3;
    logic [6:0]   w_f7;
    logic [N-1:0] w_imm_i;
    logic [N-1:0] w_imm_u;
    logic [N-1:0] w_shamt;
    logic [31:0]  w_u_raw;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_u_raw  = {instr[31:12], 12'h000};
    assign w_imm_i  = N'($signed(instr[31:20]));
    assign w_imm_u  = N'($signed(w_u_raw));
    assign w_shamt  = N'(instr[24:20]);

    alu_op_e      w_op;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic         w_wr;
    logic         w_br;
    logic         w_ill;

    always_comb begin
        w_op  = ALU_ADD;
        w_a   = '0;
        w_b   = '0;
        w_wr  = 1'b0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a   = rs1;
                w_b   = rs2;
                w_wr  = 1'b1;
                w_op  = arith_op(w_f3, instr[30]);
                w_ill = (w_f3 == F3_SLTU) ||
                        !((w_f7 == F7_BASE) ||
                          ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA))));
            end
            OPC_OP_IMM: begin
                w_a  = rs1;
                w_wr = 1'b1;
                // instr[30] is an immediate bit except for the right-shift pair
                w_op = arith_op(w_f3, (w_f3 == F3_SRL_SRA) && instr[30]);
                if ((w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA)) begin
                    w_b = w_shamt;
                end else begin
                    w_b = w_imm_i;
                end
                w_ill = (w_f3 == F3_SLTU) ||
                        ((w_f3 == F3_SLL) && (w_f7 != F7_BASE)) ||
                        ((w_f3 == F3_SRL_SRA) && (w_f7 != F7_BASE) && (w_f7 != F7_ALT));
            end
            OPC_LUI: begin
                w_b  = w_imm_u;
                w_wr = 1'b1;
            end
            OPC_AUIPC: begin
                w_a  = pc;
                w_b  = w_imm_u;
                w_wr = 1'b1;
            end
            OPC_BRANCH: begin
                w_a  = rs1;
                w_b  = rs2;
                w_br = 1'b1;
                case (w_f3)
                    F3_BEQ, F3_BNE: w_op  = ALU_SUB;
                    F3_BLT, F3_BGE: w_op  = ALU_SLT;
                    default:        w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    logic w_rd_zero;
    assign w_rd_zero = (instr[11:7] == 5'd0);

    always_comb begin
        op        = w_op;
        a         = w_a;
        b         = w_b;
        rd        = 5'd0;
        reg_write = 1'b0;
        is_branch = w_br;
        illegal   = w_ill;
        if (w_ill) begin
            op        = ALU_ADD;
            a         = '0;
            b         = '0;
            is_branch = 1'b0;
        end else if (w_wr) begin
            rd        = instr[11:7];
            reg_write = !w_rd_zero;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register: decodes one RV32I instruction per handshake and
// holds ALU operands/op stable for the execute stage under backpressure.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_op,
    output logic [4:0]   rd,
    output logic         reg_write,
    output logic         is_branch,
    output logic         illegal
);

    logic [4:0]   w_op;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [4:0]   w_rd;
    logic         w_reg_write;
    logic         w_is_branch;
    logic         w_illegal;

    alu_decode #(.N(N)) u_decode (
        .instr     (instr),
        .pc        (pc),
        .rs1       (rs1_data),
        .rs2       (rs2_data),
        .op        (w_op),
        .a         (w_a),
        .b         (w_b),
        .rd        (w_rd),
        .reg_write (w_reg_write),
        .is_branch (w_is_branch),
        .illegal   (w_illegal)
    );

    logic         r_valid;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [4:0]   r_op;
    logic [4:0]   r_rd;
    logic         r_reg_write;
    logic         r_is_branch;
    logic         r_illegal;
    logic         w_accept;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Payload only loads on accept, so a stalled entry stays bit-stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= ALU_ADD;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (w_accept) begin
                r_a         <= w_a;
                r_b         <= w_b;
                r_op        <= w_op;
                r_rd        <= w_rd;
                r_reg_write <= w_reg_write;
                r_is_branch <= w_is_branch;
                r_illegal   <= w_illegal;
            end
        end
    end

    assign out_valid = r_valid;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign is_branch = r_is_branch;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus handshake,
// flush and asynchronous-reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .rd        (rd),
        .reg_write (reg_write),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] d,
                                input logic rw, input logic br, input logic ill);
        vec_t v;
        v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
        v.op = op; v.a = a; v.b = b; v.rd = d;
        v.rw = rw; v.br = br; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr    = v.instr;
        pc       = v.pc;
        rs1_data = v.rs1;
        rs2_data = v.rs2;
    endtask

    task automatic check_out(input vec_t v, input int idx);
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d alu_op", idx),    32'(alu_op),    32'(v.op));
        chk($sformatf("v%0d alu_a", idx),     alu_a,          v.a);
        chk($sformatf("v%0d alu_b", idx),     alu_b,          v.b);
        chk($sformatf("v%0d rd", idx),        32'(rd),        32'(v.rd));
        chk($sformatf("v%0d reg_write", idx), 32'(reg_write), 32'(v.rw));
        chk($sformatf("v%0d is_branch", idx), 32'(is_branch), 32'(v.br));
        chk($sformatf("v%0d illegal", idx),   32'(illegal),   32'(v.ill));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " alu_op"},    32'(alu_op),    32'd0);
        chk({tag, " alu_a"},     alu_a,          32'd0);
        chk({tag, " alu_b"},     alu_b,          32'd0);
        chk({tag, " rd"},        32'(rd),        32'd0);
        chk({tag, " reg_write"}, 32'(reg_write), 32'd0);
        chk({tag, " is_branch"}, 32'(is_branch), 32'd0);
        chk({tag, " illegal"},   32'(illegal),   32'd0);
        chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    endtask

    vec_t v_add, v_sub, v_lui;

    initial begin
        //          instr         pc          rs1           rs2         op  a             b             rd rw br il
        vecs.push_back(mk(32'h002081B3, 32'h0,    32'h5,        32'h7,     5'd0, 32'h5,        32'h7,        5'd3, 1, 0, 0)); // ADD
        vecs.push_back(mk(32'hFFF00093, 32'h0,    32'h11,       32'h99,    5'd0, 32'h11,       32'hFFFFFFFF, 5'd1, 1, 0, 0)); // ADDI -1
        vecs.push_back(mk(32'h4040D113, 32'h0,    32'h80,       32'h99,    5'd7, 32'h80,       32'h4,        5'd2, 1, 0, 0)); // SRAI 4
        vecs.push_back(mk(32'h407302B3, 32'h0,    32'hA,        32'h3,     5'd1, 32'hA,        32'h3,        5'd5, 1, 0, 0)); // SUB
        vecs.push_back(mk(32'h022081B3, 32'h0,    32'h5,        32'h7,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // f7=0000001
        vecs.push_back(mk(32'h0020E063, 32'h0,    32'h5,        32'h7,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // BLTU
        vecs.push_back(mk(32'h123452B7, 32'h400,  32'hAAAA,     32'hBBBB,  5'd0, 32'h0,        32'h12345000, 5'd5, 1, 0, 0)); // LUI
        vecs.push_back(mk(32'hFFFFF217, 32'h1000, 32'h1,        32'h2,     5'd0, 32'h1000,     32'hFFFFF000, 5'd4, 1, 0, 0)); // AUIPC
        vecs.push_back(mk(32'h00209463, 32'h0,    32'h9,        32'h9,     5'd1, 32'h9,        32'h9,        5'd0, 0, 1, 0)); // BNE
        vecs.push_back(mk(32'h0020D063, 32'h0,    32'hFFFFFFFE, 32'h4,     5'd8, 32'hFFFFFFFE, 32'h4,        5'd0, 0, 1, 0)); // BGE
        vecs.push_back(mk(32'h0020F063, 32'h0,    32'h1,        32'h2,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // BGEU
        vecs.push_back(mk(32'h0020A1B3, 32'h0,    32'h1,        32'h2,     5'd8, 32'h1,        32'h2,        5'd3, 1, 0, 0)); // SLT
        vecs.push_back(mk(32'h0020B1B3, 32'h0,    32'h1,        32'h2,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // SLTU
        vecs.push_back(mk(32'h00208033, 32'h0,    32'h1,        32'h2,     5'd0, 32'h1,        32'h2,        5'd0, 0, 0, 0)); // ADD x0
        vecs.push_back(mk(32'h0020D1B3, 32'h0,    32'h3,        32'h4,     5'd6, 32'h3,        32'h4,        5'd3, 1, 0, 0)); // SRL
        vecs.push_back(mk(32'h4020D1B3, 32'h0,    32'h3,        32'h4,     5'd7, 32'h3,        32'h4,        5'd3, 1, 0, 0)); // SRA
        vecs.push_back(mk(32'h4020F1B3, 32'h0,    32'h3,        32'h4,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // AND f7=alt
        vecs.push_back(mk(32'h40309113, 32'h0,    32'h55,       32'h4,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // SLLI f7=alt
        vecs.push_back(mk(32'h0F017093, 32'h0,    32'h1234,     32'h0,     5'd2, 32'h1234,     32'hF0,       5'd1, 1, 0, 0)); // ANDI
        vecs.push_back(mk(32'h00000003, 32'h0,    32'h1,        32'h2,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // LOAD
        vecs.push_back(mk(32'h00003093, 32'h0,    32'h1,        32'h2,     5'd0, 32'h0,        32'h0,        5'd0, 0, 0, 1)); // SLTIU
        vecs.push_back(mk(32'h0020C1B3, 32'h0,    32'h6,        32'h3,     5'd4, 32'h6,        32'h3,        5'd3, 1, 0, 0)); // XOR
        vecs.push_back(mk(32'h0020E1B3, 32'h0,    32'h6,        32'h3,     5'd3, 32'h6,        32'h3,        5'd3, 1, 0, 0)); // OR
        v_add = vecs[0];
        v_sub = vecs[3];
        v_lui = vecs[6];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back decode table, one instruction per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check_out(vecs[i], i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // backpressure: ADD held for 3 cycles while SUB waits
        @(negedge clk);
        drive(v_add);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out(v_add, 100);
        @(negedge clk);
        drive(v_sub);
        out_ready = 1'b0;
        #1;
        chk("stall in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_out(v_add, 101 + c);
            chk($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_out(v_sub, 110);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-release out_valid", 32'(out_valid), 32'd0);

        // flush wins over a same-cycle accept
        @(negedge clk);
        drive(v_sub);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(v_add);
        @(posedge clk);
        #1;
        check_out(v_add, 120);

        // flush kills a stalled entry
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("held out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("stall flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;

        // asynchronous reset during a stall clears before the next edge
        @(negedge clk);
        drive(v_lui);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out(v_lui, 130);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async reset");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after reset out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
